// File: rtl/bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bit_serializer_pkg
// Shared definitions for the bit serializer and the blocks that consume its
// stream (sequence detector, top-level datapath).
//   DEFAULT_WIDTH : default number of bits per loaded word.
//   state_t       : serializer state encodings (IDLE=0, SHIFT=1, PARITY=2).
//                   The PARITY encoding is reserved even when the parity bit
//                   is not built, so every consumer agrees on the values.
// -----------------------------------------------------------------------------
package bit_serializer_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serializer_shreg.sv
// -----------------------------------------------------------------------------
// ser_shreg
// WIDTH-bit parallel-load / shift-left register. Load has priority over shift;
// with neither asserted the contents are held. Shifting fills with zeros.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset (clears the register)
//   i_load  : capture i_data
//   i_shift : shift left by one, zero fill
//   i_data  : parallel load word
//   o_msb   : current most significant bit (the bit being presented)
// -----------------------------------------------------------------------------
module ser_shreg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the register is reset (not left unknown) because
  // its MSB is visible on the serial output straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_q[WIDTH-1];

endmodule

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Accepts a parallel word over a valid/ready handshake and presents it one bit
// per consume, MSB first, on ser_out. A bit is consumed on a clock edge where
// ser_valid=1 and ser_en=1; ser_en=0 stalls indefinitely. The cycle that
// consumes the final bit also accepts the next word, so back-to-back words
// stream without a gap.
//
// Optional build macro SER_PARITY_EN: append an even-parity (XOR) bit after
// the data bits; the word becomes WIDTH+1 bits long and the back-to-back load
// window moves to the parity-consume cycle.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset (drops any word in flight)
//   load_valid : upstream word available
//   load_data  : word to serialize, sampled on load_valid && load_ready
//   load_ready : a word can be accepted this cycle
//   ser_en     : downstream advance
//   ser_out    : current serial bit (0 when idle)
//   ser_valid  : ser_out holds a valid bit
//   done       : one-cycle pulse after the last bit of a word is consumed
//   busy_cnt   : bits remaining in the current word, including the current one
// -----------------------------------------------------------------------------
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done,
  output logic [CNT_W-1:0] busy_cnt
);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_done;

  logic w_msb;
  logic w_shift;
  logic w_load;
  logic w_data_last;   // final data bit consumed this cycle
  logic w_word_end;    // final bit of the word (data or parity) consumed

  assign w_shift     = (r_state == ST_SHIFT) && ser_en;
  assign w_data_last = w_shift && (r_count == CNT_W'(1));

`ifdef SER_PARITY_EN
  logic r_parity;
  assign w_word_end = (r_state == ST_PARITY) && ser_en;
`else
  assign w_word_end = w_data_last;
`endif

  // Ready in IDLE and on the word-end cycle, which is what lets a new word
  // follow the previous one with no idle bubble.
  assign load_ready = (r_state == ST_IDLE) || w_word_end;
  assign w_load     = load_valid && load_ready;

  ser_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (load_data),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_done   <= 1'b0;
`ifdef SER_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_done <= w_word_end;
      if (w_load) begin
        r_state  <= ST_SHIFT;
        r_count  <= CNT_W'(WIDTH);
`ifdef SER_PARITY_EN
        // Parity is taken from the word as loaded; the shift register no
        // longer holds it once bits start leaving.
        r_parity <= ^load_data;
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_count <= '0;
          end
          ST_SHIFT: begin
            if (w_data_last) begin
`ifdef SER_PARITY_EN
              r_state <= ST_PARITY;
              r_count <= CNT_W'(1);
`else
              r_state <= ST_IDLE;
              r_count <= '0;
`endif
            end else if (ser_en) begin
              r_count <= r_count - CNT_W'(1);
            end
          end
`ifdef SER_PARITY_EN
          ST_PARITY: begin
            if (ser_en) begin
              r_state <= ST_IDLE;
              r_count <= '0;
            end
          end
`endif
          default: begin
            r_state <= ST_IDLE;
            r_count <= '0;
          end
        endcase
      end
    end
  end

  assign ser_valid = (r_state != ST_IDLE);
  assign done      = r_done;
  assign busy_cnt  = r_count;

`ifdef SER_PARITY_EN
  assign ser_out = (r_state == ST_SHIFT)  ? w_msb    :
                   (r_state == ST_PARITY) ? r_parity : 1'b0;
`else
  assign ser_out = (r_state == ST_SHIFT) ? w_msb : 1'b0;
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
// Directed bench for bit_serializer (WIDTH=16). Inputs are driven and outputs
// sampled on the falling edge; the design acts on the rising edge. Expected
// bits come from the word itself: position p < 16 is word[15-p], and in a
// SER_PARITY_EN build position 16 is the XOR of the word.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
  localparam int LEN = WIDTH + 1;
`else
  localparam int LEN = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_ready;
  logic             ser_en = 1'b0;
  logic             ser_out;
  logic             ser_valid;
  logic             done;
  logic [CNT_W-1:0] busy_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  bit_serializer #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ser_en     (ser_en),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .done       (done),
    .busy_cnt   (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int pos);
    if (pos < WIDTH) return w[WIDTH-1-pos];
    return ^w;
  endfunction

  function automatic int exp_busy(input int pos);
    if (pos < WIDTH) return WIDTH - pos;
    return 1;
  endfunction

  // Handshake one word while idle; returns at the falling edge where bit 0
  // is visible.
  task automatic load_word(input logic [WIDTH-1:0] w);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = w;
    ser_en     = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Check and consume positions first..last with ser_en held high.
  task automatic stream_range(input logic [WIDTH-1:0] w, input int first, input int last,
                              input string tag);
    for (int p = first; p <= last; p++) begin
      check($sformatf("%s valid[%0d]", tag, p), 64'(ser_valid), 64'(1));
      check($sformatf("%s bit[%0d]", tag, p), 64'(ser_out), 64'(exp_bit(w, p)));
      check($sformatf("%s busy[%0d]", tag, p), 64'(busy_cnt), 64'(exp_busy(p)));
      check($sformatf("%s done[%0d]", tag, p), 64'(done), 64'(0));
      check($sformatf("%s ready[%0d]", tag, p), 64'(load_ready), 64'(p == LEN - 1));
      ser_en = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic expect_done(input string tag);
    check({tag, " done"}, 64'(done), 64'(1));
    check({tag, " idle valid"}, 64'(ser_valid), 64'(0));
    check({tag, " idle ready"}, 64'(load_ready), 64'(1));
    check({tag, " idle busy"}, 64'(busy_cnt), 64'(0));
    check({tag, " idle out"}, 64'(ser_out), 64'(0));
    @(negedge clk);
    check({tag, " done clears"}, 64'(done), 64'(0));
  endtask

  initial begin
    int nd;
    int d1;
    int d2;
    logic [WIDTH-1:0] w1;
    logic [WIDTH-1:0] wb;
    w1 = 16'b1011011010110011;

    // Reset state, while held and after release.
    repeat (2) @(negedge clk);
    check("rst ready", 64'(load_ready), 64'(1));
    check("rst valid", 64'(ser_valid), 64'(0));
    check("rst out", 64'(ser_out), 64'(0));
    check("rst done", 64'(done), 64'(0));
    check("rst busy", 64'(busy_cnt), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post-rst ready", 64'(load_ready), 64'(1));
    check("post-rst valid", 64'(ser_valid), 64'(0));

    // 1: continuous consume, MSB first: 1,0,1,1,0,1,1,0,1,0,1,1,0,0,1,1.
    load_word(w1);
    stream_range(w1, 0, LEN - 1, "t1");
    expect_done("t1");

    // 2: ser_en low then high each cycle; every bit is held two cycles.
    load_word(w1);
    nd = 0;
    for (int k = 0; k < 2 * LEN; k++) begin
      check($sformatf("t2 valid[%0d]", k), 64'(ser_valid), 64'(1));
      check($sformatf("t2 bit[%0d]", k), 64'(ser_out), 64'(exp_bit(w1, k / 2)));
      check($sformatf("t2 busy[%0d]", k), 64'(busy_cnt), 64'(exp_busy(k / 2)));
      if (done) nd++;
      ser_en = (k % 2 == 1);
      @(negedge clk);
    end
    check("t2 done at end", 64'(done), 64'(1));
    check("t2 idle valid", 64'(ser_valid), 64'(0));
    for (int k = 0; k < 3; k++) begin
      if (done) nd++;
      ser_en = 1'b1;
      @(negedge clk);
    end
    check("t2 done pulses", 64'(nd), 64'(1));

    // 3: back-to-back FFFF then 0000 with load_valid held; no valid gap.
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    ser_en     = 1'b1;
    @(negedge clk);
    load_data = 16'h0000;
    nd = 0;
    d1 = -1;
    d2 = -1;
    for (int k = 0; k < 2 * LEN + 2; k++) begin
      wb = (k < LEN) ? 16'hFFFF : 16'h0000;
      if (k < 2 * LEN) begin
        check($sformatf("t3 valid[%0d]", k), 64'(ser_valid), 64'(1));
        check($sformatf("t3 bit[%0d]", k), 64'(ser_out), 64'(exp_bit(wb, k % LEN)));
        check($sformatf("t3 busy[%0d]", k), 64'(busy_cnt), 64'(exp_busy(k % LEN)));
        check($sformatf("t3 ready[%0d]", k), 64'(load_ready), 64'((k % LEN) == LEN - 1));
      end
      if (done) begin
        nd++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k == 2 * LEN - 1) load_valid = 1'b0;
      @(negedge clk);
    end
    check("t3 done pulses", 64'(nd), 64'(2));
    check("t3 first done", 64'(d1), 64'(LEN));
    check("t3 second done", 64'(d2), 64'(2 * LEN));
    check("t3 idle valid", 64'(ser_valid), 64'(0));

    // 4: asynchronous reset between edges after 5 bits of A5A5.
    load_word(16'hA5A5);
    stream_range(16'hA5A5, 0, 4, "t4");
    check("t4 busy before rst", 64'(busy_cnt), 64'(WIDTH - 5));
    #2 rst = 1'b1;
    #1;
    check("t4 async valid", 64'(ser_valid), 64'(0));
    check("t4 async out", 64'(ser_out), 64'(0));
    check("t4 async busy", 64'(busy_cnt), 64'(0));
    check("t4 async ready", 64'(load_ready), 64'(1));
    #1 rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("t4 no done after rst", 64'(nd), 64'(0));
    check("t4 idle valid", 64'(ser_valid), 64'(0));
    load_word(16'hA5A5);
    stream_range(16'hA5A5, 0, LEN - 1, "t4 reload");
    expect_done("t4");

    // 5: load_valid pulsed mid-word (not the last bit) is ignored.
    load_word(16'h5AF0);
    stream_range(16'h5AF0, 0, 2, "t5");
    load_valid = 1'b1;
    load_data  = 16'h1234;
    stream_range(16'h5AF0, 3, 3, "t5");
    load_valid = 1'b0;
    stream_range(16'h5AF0, 4, LEN - 1, "t5");
    expect_done("t5");
    check("t5 stays idle", 64'(ser_valid), 64'(0));

    // 6: short word; with SER_PARITY_EN its appended bit is 0 (two ones).
    // 16'b1011011010110011 above has ten ones, so its parity bit is also 0.
    load_word(16'h0003);
    stream_range(16'h0003, 0, LEN - 1, "t6");
    expect_done("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
